// File: rtl/regfile_pkg.sv
// Shared definitions for the layer-engine register bank: region decode and command bit layout.
package regfile_pkg;

  typedef enum logic [2:0] {
    REG_CFG,
    REG_STAT,
    REG_CMD,
    REG_STICKY,
    REG_MASK,
    REG_NONE
  } region_t;

  localparam int unsigned CMD_COMMIT_BIT = 0;

  function automatic region_t decode_region(
    input int unsigned addr,
    input int unsigned n_cfg,
    input int unsigned stat_base,
    input int unsigned n_stat,
    input int unsigned cmd_addr,
    input int unsigned sticky_addr,
    input int unsigned mask_addr
  );
    if (addr < n_cfg)                                        return REG_CFG;
    if ((addr >= stat_base) && (addr < stat_base + n_stat))  return REG_STAT;
    if (addr == cmd_addr)                                    return REG_CMD;
    if (addr == sticky_addr)                                 return REG_STICKY;
    if (addr == mask_addr)                                   return REG_MASK;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/regfile_sticky.sv
// Sticky event bank: per-bit set pulses, write-1-to-clear, interrupt mask and registered irq.
module regfile_sticky #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] set_bits,
  input  logic [DATA_W-1:0] clr_bits,
  input  logic              mask_we,
  input  logic [DATA_W-1:0] mask_wdata,
  output logic [DATA_W-1:0] sticky,
  output logic [DATA_W-1:0] mask,
  output logic              irq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      // Set is OR-ed in after the clear so a coincident event survives W1C.
      sticky <= (sticky & ~clr_bits) | set_bits;
      if (mask_we) mask <= mask_wdata;
      irq <= |(sticky & mask);
    end
  end

endmodule

// File: rtl/regfile_bank.sv
// Bus-accessible config/status bank with shadow/active config, command pulses and sticky events.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned N_CFG       = 32,
  parameter int unsigned N_STAT      = 8,
  parameter int unsigned STAT_BASE   = 8'h40,
  parameter int unsigned CMD_ADDR    = 8'h80,
  parameter int unsigned STICKY_ADDR = 8'h81,
  parameter int unsigned MASK_ADDR   = 8'h82
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_req,
  input  logic                     bus_we,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic [DATA_W-1:0]        bus_wdata,
  output logic                     bus_ack,
  output logic                     bus_err,
  output logic [DATA_W-1:0]        bus_rdata,
  input  logic                     commit_req,
  output logic [N_CFG*DATA_W-1:0]  cfg_active,
  input  logic [N_STAT*DATA_W-1:0] status_in,
  input  logic [DATA_W-1:0]        event_in,
  output logic [DATA_W-1:0]        cmd_pulse,
  output logic                     irq
);

  if ((N_CFG > STAT_BASE) || (STAT_BASE + N_STAT > CMD_ADDR) ||
      (STICKY_ADDR < STAT_BASE + N_STAT) || (MASK_ADDR < STAT_BASE + N_STAT) ||
      (CMD_ADDR == STICKY_ADDR) || (CMD_ADDR == MASK_ADDR) || (STICKY_ADDR == MASK_ADDR)) begin : g_bad_map
    $error("regfile_bank: overlapping register regions");
  end

  logic [DATA_W-1:0] shadow [N_CFG];
  logic [31:0]       addr_w;
  region_t           region;
  logic              accept;
  logic              wr;
  logic              commit;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic [DATA_W-1:0] sticky_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] clr_bits;

  assign addr_w = 32'(bus_addr);
  assign region = decode_region(addr_w, N_CFG, STAT_BASE, N_STAT, CMD_ADDR, STICKY_ADDR, MASK_ADDR);
  assign accept = bus_req && !bus_ack;
  assign wr     = accept && bus_we;
  assign commit = commit_req || (wr && (region == REG_CMD) && bus_wdata[CMD_COMMIT_BIT]);
  assign clr_bits = (wr && (region == REG_STICKY)) ? bus_wdata : '0;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (region)
      REG_CFG: begin
        for (int unsigned i = 0; i < N_CFG; i++)
          if (addr_w == i) rd_data = shadow[i];
      end
      REG_STAT: begin
        rd_err = bus_we;
        for (int unsigned i = 0; i < N_STAT; i++)
          if (addr_w == STAT_BASE + i) rd_data = status_in[i*DATA_W +: DATA_W];
      end
      REG_CMD:    rd_data = '0;
      REG_STICKY: rd_data = sticky_q;
      REG_MASK:   rd_data = mask_q;
      default:    rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack    <= 1'b0;
      bus_err    <= 1'b0;
      bus_rdata  <= '0;
      cmd_pulse  <= '0;
      cfg_active <= '0;
      for (int unsigned i = 0; i < N_CFG; i++) shadow[i] <= '0;
    end else begin
      bus_ack   <= accept;
      bus_err   <= accept && rd_err;
      bus_rdata <= (accept && !bus_we) ? rd_data : '0;
      cmd_pulse <= (wr && (region == REG_CMD)) ? bus_wdata : '0;
      // Commit copies pre-edge shadow, so a same-cycle shadow write lands only in shadow.
      for (int unsigned i = 0; i < N_CFG; i++) begin
        if (commit) cfg_active[i*DATA_W +: DATA_W] <= shadow[i];
        if (wr && (region == REG_CFG) && (addr_w == i)) shadow[i] <= bus_wdata;
      end
    end
  end

  regfile_sticky #(
    .DATA_W(DATA_W)
  ) u_sticky (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_bits  (event_in),
    .clr_bits  (clr_bits),
    .mask_we   (wr && (region == REG_MASK)),
    .mask_wdata(bus_wdata),
    .sticky    (sticky_q),
    .mask      (mask_q),
    .irq       (irq)
  );

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank with a read-response scoreboard.
module tb_regfile_bank;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned N_CFG  = 32;
  localparam int unsigned N_STAT = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     bus_req, bus_we;
  logic [ADDR_W-1:0]        bus_addr;
  logic [DATA_W-1:0]        bus_wdata;
  logic                     bus_ack, bus_err;
  logic [DATA_W-1:0]        bus_rdata;
  logic                     commit_req;
  logic [N_CFG*DATA_W-1:0]  cfg_active;
  logic [N_STAT*DATA_W-1:0] status_in;
  logic [DATA_W-1:0]        event_in;
  logic [DATA_W-1:0]        cmd_pulse;
  logic                     irq;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [16:0] sb_q [$];

  regfile_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CFG(N_CFG), .N_STAT(N_STAT),
    .STAT_BASE(8'h40), .CMD_ADDR(8'h80), .STICKY_ADDR(8'h81), .MASK_ADDR(8'h82)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .commit_req(commit_req), .cfg_active(cfg_active), .status_in(status_in),
    .event_in(event_in), .cmd_pulse(cmd_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] act(input int unsigned i);
    return cfg_active[i*DATA_W +: DATA_W];
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus_ack) begin
      if (sb_q.size() == 0) chk("unexpected_ack", 32'(bus_ack), 32'd0);
      else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        chk("rdata", 32'(bus_rdata), 32'(e[16:1]));
        chk("err", 32'(bus_err), 32'(e[0]));
      end
    end
  end

  task automatic xact(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                      input logic [15:0] ev, input logic cmt,
                      input logic [15:0] exp_rd, input logic exp_err);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    event_in = ev; commit_req = cmt;
    sb_q.push_back({exp_rd, exp_err});
    @(posedge clk);
    #1;
    bus_req = 1'b0; event_in = '0; commit_req = 1'b0;
    @(negedge clk);
    chk("ack_t1", 32'(bus_ack), 32'd1);
    @(negedge clk);
    chk("ack_t2", 32'(bus_ack), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    commit_req = 1'b0; event_in = '0;
    for (int i = 0; i < int'(N_STAT); i++) status_in[i*DATA_W +: DATA_W] = 16'hA000 + 16'(i);
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus_ack), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", 32'(bus_rdata), 32'd0);
    chk("rst_active", 32'(|cfg_active), 32'd0);
    chk("rst_cmd", 32'(cmd_pulse), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    xact(0, 8'h00, 0, 0, 0, 16'h0000, 0);
    xact(0, 8'h81, 0, 0, 0, 16'h0000, 0);
    xact(0, 8'h82, 0, 0, 0, 16'h0000, 0);

    xact(1, 8'h03, 16'h1234, 0, 0, 16'h0000, 0);
    xact(0, 8'h03, 0, 0, 0, 16'h1234, 0);
    chk("act3_before", 32'(act(3)), 32'h0);
    @(negedge clk); commit_req = 1'b1;
    @(posedge clk); #1 commit_req = 1'b0;
    chk("act3_after", 32'(act(3)), 32'h1234);

    xact(1, 8'h05, 16'h0011, 0, 1, 16'h0000, 0);
    chk("act5_first", 32'(act(5)), 32'h0);
    @(negedge clk); commit_req = 1'b1;
    @(posedge clk); #1 commit_req = 1'b0;
    chk("act5_0011", 32'(act(5)), 32'h0011);
    xact(1, 8'h05, 16'hBEEF, 0, 1, 16'h0000, 0);
    chk("act5_prewrite", 32'(act(5)), 32'h0011);
    xact(0, 8'h05, 0, 0, 0, 16'hBEEF, 0);

    xact(1, 8'h07, 16'h7777, 0, 0, 16'h0000, 0);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 8'h80; bus_wdata = 16'h0006;
    sb_q.push_back({16'h0000, 1'b0});
    @(posedge clk); #1 bus_req = 1'b0;
    @(negedge clk);
    chk("cmd_pulse_t1", 32'(cmd_pulse), 32'h0006);
    @(negedge clk);
    chk("cmd_pulse_t2", 32'(cmd_pulse), 32'h0);
    chk("act7_nocommit", 32'(act(7)), 32'h0);
    xact(1, 8'h80, 16'h0001, 0, 0, 16'h0000, 0);
    chk("act7_swcommit", 32'(act(7)), 32'h7777);
    chk("act5_swcommit", 32'(act(5)), 32'hBEEF);
    xact(0, 8'h80, 0, 0, 0, 16'h0000, 0);

    xact(1, 8'h82, 16'h0004, 0, 0, 16'h0000, 0);
    @(negedge clk); event_in = 16'h0004;
    @(posedge clk); #1 event_in = '0;
    chk("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_rise", 32'(irq), 32'd1);
    xact(0, 8'h81, 0, 0, 0, 16'h0004, 0);
    xact(1, 8'h81, 16'h0004, 0, 0, 16'h0000, 0);
    chk("irq_fall", 32'(irq), 32'd0);
    xact(0, 8'h81, 0, 0, 0, 16'h0000, 0);
    xact(1, 8'h81, 16'h0004, 16'h0004, 0, 16'h0000, 0);
    xact(0, 8'h81, 0, 0, 0, 16'h0004, 0);
    chk("irq_setwins", 32'(irq), 32'd1);

    xact(0, 8'h7F, 0, 0, 0, 16'h0000, 1);
    xact(1, 8'h40, 16'h5555, 0, 0, 16'h0000, 1);
    xact(0, 8'h40, 0, 0, 0, 16'hA000, 0);
    xact(0, 8'h42, 0, 0, 0, 16'hA002, 0);

    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 8'h09; bus_wdata = 16'hAAAA;
    @(posedge clk); #1 rst_n = 1'b0; bus_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_ack", 32'(bus_ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_ack", 32'(bus_ack), 32'd0);
    chk("rst_post_cmd", 32'(cmd_pulse), 32'd0);
    chk("rst_post_act", 32'(|cfg_active), 32'd0);
    xact(0, 8'h09, 0, 0, 0, 16'h0000, 0);
    xact(0, 8'h05, 0, 0, 0, 16'h0000, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised configuration/status register bank for the accelerator's layer engines (conv/pool/nl/fc).
- Replaces the flat register-signal bundle with a bus-accessible bank that has:
  - double-buffered (shadow/active) config registers,
  - self-clearing command pulses,
  - read-only status capture,
  - sticky event bits with write-1-to-clear and a masked interrupt.
- Sits between the host register bus and the layer controllers. Engines see only active config, so a layer in progress is never disturbed by host writes.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 8, bus word-address width.
- N_CFG, 32, number of RW config registers at addresses 0..N_CFG-1.
- N_STAT, 8, number of RO status registers at STAT_BASE..STAT_BASE+N_STAT-1.
- STAT_BASE, 8'h40, base address of the status region.
- CMD_ADDR, 8'h80, command register (write-only pulses).
- STICKY_ADDR, 8'h81, sticky event register (read, W1C).
- MASK_ADDR, 8'h82, interrupt mask register (RW).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- bus_req  in  1  transaction request
- bus_we  in  1  1=write, 0=read
- bus_addr  in  ADDR_W  word address
- bus_wdata  in  DATA_W  write data
- bus_ack  out  1  one-cycle transaction complete
- bus_err  out  1  valid with bus_ack; unmapped address or illegal access
- bus_rdata  out  DATA_W  read data, valid with bus_ack
- commit_req  in  1  hardware commit strobe (layer start)
- cfg_active  out  N_CFG*DATA_W  active config, register i at bits [i*DATA_W +: DATA_W]
- status_in  in  N_STAT*DATA_W  live status from engines
- event_in  in  DATA_W  per-bit event set pulses
- cmd_pulse  out  DATA_W  single-cycle command strobes
- irq  out  1  OR of (sticky & mask), registered

Behaviour:
- Reset (rst_n low, async): all of the following are 0 — bus_ack, bus_err, bus_rdata, shadow regs, active regs, sticky, mask, cmd_pulse, irq.
- Accept rule: a transaction is accepted in cycle t when bus_req=1 and bus_ack=0.
  - bus_ack=1 in cycle t+1 for exactly one cycle.
  - At most one transaction per two cycles. bus_req held through the ack cycle is not re-accepted in that cycle.
- Write, config region: shadow[addr] <= wdata at the accept edge. Active is unchanged.
- Write, MASK_ADDR: mask <= wdata.
- Write, STICKY_ADDR: sticky <= sticky & ~wdata (W1C).
- Write, CMD_ADDR:
  - cmd_pulse <= wdata for exactly one cycle (cycle t+1), then 0.
  - Bit 0 is reserved as software commit and also triggers a commit.
- Write, status region: no effect, bus_err=1.
- Read:
  - bus_rdata at t+1 comes from the captured source:
    - config: shadow value,
    - status: status_in sampled at the accept edge,
    - sticky, mask: current value,
    - CMD_ADDR: reads 0, bus_err=0.
  - Unmapped address: rdata=0, err=1.
- Commit (commit_req=1, or CMD bit 0 written):
  - active <= shadow for all N_CFG registers on the next edge. Latency is one cycle from strobe to cfg_active change.
  - A shadow write accepted in the same cycle as commit_req: active takes the pre-write shadow value; shadow takes the new value.
  - A commit via CMD bit 0 uses shadow as it was before that edge.
- Sticky:
  - sticky[i] sets on event_in[i]=1.
  - If set and W1C clear of the same bit occur in the same cycle, set wins.
- irq <= |(sticky & mask), one cycle after the sticky/mask update.
- Asserting rst_n low mid-transaction aborts it: no ack is generated after reset release and pending cmd_pulse is dropped.
- Parameter check: elaboration error if the config, status and command regions overlap, or if N_CFG > STAT_BASE.

Decomposition:
- Package regfile_pkg holds:
  - region enum {REG_CFG, REG_STAT, REG_CMD, REG_STICKY, REG_MASK, REG_NONE},
  - CMD_COMMIT_BIT = 0,
  - the decode function addr -> region.
- One sub-module, regfile_sticky: a DATA_W sticky bank with set input, W1C input, mask and registered irq.

Test Plan:
- Reset, then read addr 0, STICKY_ADDR and MASK_ADDR -> rdata=0, err=0, ack exactly one cycle after accept.
- Write 0x1234 to cfg 3 -> readback 0x1234; cfg_active reg 3 stays 0 until commit_req, then equals 0x1234 one cycle later.
- Same-cycle shadow write 0xBEEF to cfg 5 (shadow previously 0x0011) and commit_req -> active[5]=0x0011, shadow[5]=0xBEEF.
- Write 0x0006 to CMD_ADDR -> cmd_pulse=0x0006 for exactly one cycle, no commit. Write 0x0001 -> commit occurs; a CMD read returns 0.
- Sticky/irq:
  - event_in=0x0004 with mask=0x0004 -> sticky=0x0004, irq=1 next cycle.
  - W1C 0x0004 -> irq falls.
  - W1C 0x0004 together with event_in=0x0004 -> bit stays set.
- Read addr 0x7F -> err=1, rdata=0. Write to STAT_BASE -> err=1, status unchanged. Assert rst_n during an accepted write -> no ack, shadow=0.
